// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, instruction width, fetch FSM encoding
// and a branch-opcode decode helper.
package mips_pkg;

   localparam int INSTR_W = 32;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef enum logic [0:0] {
      FETCH_RUN    = 1'b0,
      FETCH_BUBBLE = 1'b1
   } fetch_state_t;

   function automatic logic is_branch(input logic [INSTR_W-1:0] instr);
      logic hit;
      case (instr[31:26])
         OP_BEQ, OP_BNE: hit = 1'b1;
         default:        hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/fetch_imem.sv
// Byte-wide instruction memory: one synchronous byte write port and one
// combinational big-endian 4-byte read port that wraps inside the array.
module fetch_imem
   import mips_pkg::*;
#(
   parameter int BYTES = 512,
   localparam int AW   = $clog2(BYTES)
) (
   input  logic               clk,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [7:0]         wdata,
   input  logic [AW-1:0]      raddr,
   output logic [INSTR_W-1:0] rdata
);

   logic [7:0] mem [BYTES];

   // Byte write; a same-cycle read still returns the pre-write byte.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = {mem[raddr],
                   mem[raddr + AW'(2'd1)],
                   mem[raddr + AW'(2'd2)],
                   mem[raddr + AW'(2'd3)]};

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and a
// RUN/BUBBLE FSM that inserts a fixed number of bubbles after BEQ/BNE.
module fetch_stage
   import mips_pkg::*;
#(
   parameter int                ADDR_W              = 32,
   parameter int                IMEM_BYTES          = 512,
   parameter int                BRANCH_STALL_CYCLES = 2,
   parameter logic [ADDR_W-1:0] RESET_PC            = '0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          imem_we,
   input  logic [$clog2(IMEM_BYTES)-1:0] imem_waddr,
   input  logic [7:0]                    imem_wdata,
   input  logic                          stall_i,
   input  logic                          redirect_valid,
   input  logic [ADDR_W-1:0]             redirect_pc,
   output logic [ADDR_W-1:0]             pc_o,
   output logic                          if_id_valid,
   output logic [INSTR_W-1:0]            if_id_instr,
   output logic [ADDR_W-1:0]             if_id_pc4,
   output logic                          branch_bubble
);

   localparam int MEM_AW = $clog2(IMEM_BYTES);
   localparam int CNT_W  = (BRANCH_STALL_CYCLES > 0) ? $clog2(BRANCH_STALL_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0]  STALL_LOAD = CNT_W'(BRANCH_STALL_CYCLES);
   localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(32'd4);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(32'd3);

   fetch_state_t         state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [ADDR_W-1:0]    pc_n, pc4_n;
   logic                 valid_n, bubble_n;
   logic [INSTR_W-1:0]   instr_n, fetch_word;
   logic [MEM_AW-1:0]    fetch_idx;

   // Narrow address spaces are zero-extended; wide ones wrap modulo the memory size.
   if (ADDR_W >= MEM_AW) begin : g_idx_slice
      assign fetch_idx = pc_o[MEM_AW-1:0];
   end else begin : g_idx_ext
      assign fetch_idx = {{(MEM_AW-ADDR_W){1'b0}}, pc_o};
   end

   fetch_imem #(.BYTES(IMEM_BYTES)) u_imem (
      .clk   (clk),
      .we    (imem_we),
      .waddr (imem_waddr),
      .wdata (imem_wdata),
      .raddr (fetch_idx),
      .rdata (fetch_word)
   );

   // Next-state logic: redirect beats stall, stall beats the FSM.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      pc_n    = pc_o;
      valid_n = if_id_valid;
      instr_n = if_id_instr;
      pc4_n   = if_id_pc4;
      if (redirect_valid) begin
         pc_n    = redirect_pc & ALIGN_MASK;
         valid_n = 1'b0;
         state_n = FETCH_RUN;
         cnt_n   = '0;
      end else if (stall_i) begin
         state_n = state;
      end else begin
         case (state)
            FETCH_RUN: begin
               valid_n = 1'b1;
               instr_n = fetch_word;
               pc4_n   = pc_o + PC_STEP;
               pc_n    = pc_o + PC_STEP;
               if ((BRANCH_STALL_CYCLES > 0) && is_branch(fetch_word)) begin
                  state_n = FETCH_BUBBLE;
                  cnt_n   = STALL_LOAD;
               end else begin
                  state_n = FETCH_RUN;
               end
            end
            FETCH_BUBBLE: begin
               valid_n = 1'b0;
               cnt_n   = cnt - CNT_W'(1'b1);
               if (cnt == CNT_W'(1'b1)) begin
                  state_n = FETCH_RUN;
               end else begin
                  state_n = FETCH_BUBBLE;
               end
            end
            default: begin
               state_n = FETCH_RUN;
               cnt_n   = '0;
            end
         endcase
      end
      bubble_n = (state_n == FETCH_BUBBLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= FETCH_RUN;
         cnt           <= '0;
         pc_o          <= RESET_PC;
         if_id_valid   <= 1'b0;
         if_id_instr   <= '0;
         if_id_pc4     <= '0;
         branch_bubble <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         pc_o          <= pc_n;
         if_id_valid   <= valid_n;
         if_id_instr   <= instr_n;
         if_id_pc4     <= pc4_n;
         branch_bubble <= bubble_n;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a stimulus process predicts each cycle's
// outputs with a bubble-debt model and a monitor compares them after the edge.
module tb_fetch_stage;

   localparam int ADDR_W = 32;
   localparam int NBYTES = 512;
   localparam int NSTALL = 2;

   logic              clk = 1'b0;
   logic              reset, imem_we, stall_i, redirect_valid;
   logic [8:0]        imem_waddr;
   logic [7:0]        imem_wdata;
   logic [31:0]       redirect_pc;
   logic [31:0]       pc_o, if_id_instr, if_id_pc4;
   logic              if_id_valid, branch_bubble;

   typedef struct packed {
      logic [31:0] pc;
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        bubble;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          passes = 0;

   logic [7:0]  mmem [NBYTES];
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid;
   int          m_left;
   logic [31:0] wimg [NBYTES/4];

   fetch_stage #(.ADDR_W(ADDR_W), .IMEM_BYTES(NBYTES), .BRANCH_STALL_CYCLES(NSTALL),
                 .RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset), .imem_we(imem_we), .imem_waddr(imem_waddr),
      .imem_wdata(imem_wdata), .stall_i(stall_i), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .pc_o(pc_o), .if_id_valid(if_id_valid),
      .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .branch_bubble(branch_bubble));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      else passes++;
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      for (int k = 0; k < 4; k++) begin
         logic [31:0] b;
         b = a + k;
         w[31-8*k -: 8] = mmem[b % NBYTES];
      end
      return w;
   endfunction

   // One clock of stimulus plus the model's prediction of the post-edge outputs.
   task automatic drive(input logic r, input logic we, input logic [8:0] wa, input logic [7:0] wd,
                        input logic st, input logic rv, input logic [31:0] rpc);
      exp_t e;
      logic [31:0] w;
      @(negedge clk);
      reset = r; imem_we = we; imem_waddr = wa; imem_wdata = wd;
      stall_i = st; redirect_valid = rv; redirect_pc = rpc;
      if (r) begin
         m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0; m_left = 0;
      end else if (rv) begin
         m_pc = {rpc[31:2], 2'b00}; m_valid = 1'b0; m_left = 0;
      end else if (st) begin
         m_left = m_left;
      end else if (m_left > 0) begin
         m_valid = 1'b0; m_left = m_left - 1;
      end else begin
         w = mem_word(m_pc);
         m_instr = w; m_valid = 1'b1; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
         if ((w[31:26] == 6'h04 || w[31:26] == 6'h05) && NSTALL > 0) m_left = NSTALL;
      end
      if (we) mmem[wa] = wd;
      e.pc = m_pc; e.valid = m_valid; e.instr = m_instr; e.pc4 = m_pc4; e.bubble = (m_left > 0);
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 9'h0, 8'h0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic redir(input logic [31:0] a, input logic st);
      drive(1'b0, 1'b0, 9'h0, 8'h0, st, 1'b1, a);
   endtask

   // Monitor: compare every presented output against the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pc_o", pc_o, e.pc);
            chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
            chk("if_id_instr", if_id_instr, e.instr);
            chk("if_id_pc4", if_id_pc4, e.pc4);
            chk("branch_bubble", {31'b0, branch_bubble}, {31'b0, e.bubble});
         end
      end
   end

   initial begin
      logic [5:0] ops [7];
      ops = '{6'h00, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h23, 6'h2B};
      reset = 1'b1; imem_we = 1'b0; imem_waddr = 9'h0; imem_wdata = 8'h0;
      stall_i = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0; m_left = 0;
      for (int i = 0; i < NBYTES; i++) mmem[i] = 8'h00;

      for (int i = 0; i < NBYTES/4; i++) wimg[i] = {ops[$urandom_range(0, 6)], 26'($urandom)};
      wimg[0]  = 32'h20010005;
      wimg[1]  = 32'h20020007;
      wimg[2]  = 32'h10220003;
      wimg[3]  = 32'h20030001;
      wimg[16] = 32'h20040002;
      wimg[17] = 32'h8C050000;
      for (int i = 0; i < NBYTES; i++) begin
         logic [31:0] wv;
         wv = wimg[i/4];
         drive(1'b1, 1'b1, 9'(i), wv[31-8*(i%4) -: 8], 1'b0, 1'b0, 32'h0);
      end

      // Free run into the BEQ at 8, then redirect to 0x43 while bubbling.
      idle(4);
      redir(32'h00000043, 1'b0);
      idle(2);
      // Three stalled cycles, then a redirect that must win over the stall.
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 9'h0, 8'h0, 1'b1, 1'b0, 32'h0);
      redir(32'h00000008, 1'b1);
      idle(1);
      // Reset on the first bubble cycle leaves no residual bubbles.
      drive(1'b1, 1'b0, 9'h0, 8'h0, 1'b0, 1'b0, 32'h0);
      idle(4);
      // Memory-end wrap and PC wrap at 2^32.
      redir(32'h000001FC, 1'b0);
      idle(3);
      redir(32'hFFFFFFFC, 1'b0);
      idle(2);
      // Write a byte of the word being fetched: old byte latched, new one on refetch.
      redir(32'h00000040, 1'b0);
      drive(1'b0, 1'b1, 9'h041, 8'hA5, 1'b0, 1'b0, 32'h0);
      redir(32'h00000040, 1'b0);
      idle(2);

      for (int i = 0; i < 3000; i++) begin
         logic r, we, st, rv;
         logic [31:0] rpc;
         r   = ($urandom_range(0, 99) < 1);
         we  = ($urandom_range(0, 99) < 30);
         st  = ($urandom_range(0, 99) < 20);
         rv  = ($urandom_range(0, 99) < 5);
         rpc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
         drive(r, we, 9'($urandom), 8'($urandom), st, rv, rpc);
      end

      @(negedge clk);
      reset = 1'b0; imem_we = 1'b0; stall_i = 1'b1; redirect_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
